// File: rtl/riscv_pkg.sv
// ============================================================================
// Module      : riscv_pkg
// Description : Opcodes, ALU function codes and mux encodings shared by the
//               multicycle datapath and its control unit.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package riscv_pkg;

   // Major opcodes recognised by the immediate generator
   localparam logic [6:0] OP_R    = 7'b1100110;
   localparam logic [6:0] OP_S    = 7'b0100011;
   localparam logic [6:0] OP_ADDI = 7'b0010011;
   localparam logic [6:0] OP_LD   = 7'b0000011;
   localparam logic [6:0] OP_U    = 7'b0110111;
   localparam logic [6:0] OP_SB   = 7'b1100111;

   // ALU operation select; unlisted codes produce zero
   typedef enum logic [2:0] {
      ALU_PASS = 3'b000,
      ALU_ADD  = 3'b001,
      ALU_SUB  = 3'b010,
      ALU_AND  = 3'b011,
      ALU_OR   = 3'b100
   } alu_funct_e;

   // ALU operand-B sources
   localparam logic [1:0] SRCB_B      = 2'b00;
   localparam logic [1:0] SRCB_FOUR   = 2'b01;
   localparam logic [1:0] SRCB_IMM    = 2'b10;
   localparam logic [1:0] SRCB_IMM_SH = 2'b11;

   // Register-bank write-back sources
   localparam logic [1:0] WB_ALUOUT = 2'b00;
   localparam logic [1:0] WB_MDR    = 2'b01;
   localparam logic [1:0] WB_IMM    = 2'b10;
   localparam logic [1:0] WB_ZERO   = 2'b11;

endpackage

`default_nettype wire

// File: rtl/datapath_mc_banco_reg.sv
// ============================================================================
// Module      : banco_reg
// Description : 32-entry register bank, two asynchronous read ports, one
//               synchronous write port, x0 hardwired to zero.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module banco_reg #(
   parameter int XLEN = 64
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            clr_i,
   input  logic            we_i,
   input  logic [4:0]      rs1_i,
   input  logic [4:0]      rs2_i,
   input  logic [4:0]      rd_i,
   input  logic [XLEN-1:0] wdata_i,
   output logic [XLEN-1:0] rdata1_o,
   output logic [XLEN-1:0] rdata2_o
);

   logic [XLEN-1:0] regs_q [32];

   // Entry 0 never accepts a write, so it stays at its reset value of zero
   for (genvar i = 0; i < 32; i++) begin : g_entry
      // Per-entry storage, cleared by either reset source
      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            regs_q[i] <= '0;
         end else if (clr_i) begin
            regs_q[i] <= '0;
         end else if (we_i && (rd_i == 5'(i)) && (i != 0)) begin
            regs_q[i] <= wdata_i;
         end
      end
   end

   // Reads see the pre-edge contents, so a same-cycle write is not forwarded
   assign rdata1_o = regs_q[rs1_i];
   assign rdata2_o = regs_q[rs2_i];

endmodule

`default_nettype wire

// File: rtl/datapath_mc.sv
// ============================================================================
// Module      : datapath_mc
// Description : Multicycle 64-bit datapath: PC, IR, A, B, ALUOut, MDR,
//               register bank, immediate generator, ALU and branch decision.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module datapath_mc
   import riscv_pkg::*;
#(
   parameter int XLEN = 64
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            Reset,
   input  logic            PCSrc,
   input  logic            PCWrite,
   input  logic            PCWriteCond,
   input  logic            BranchOp,
   input  logic [2:0]      ALUFunct,
   input  logic            ALUSrcA,
   input  logic [1:0]      ALUSrcB,
   input  logic            LoadRegA,
   input  logic            LoadRegB,
   input  logic            LoadALUOut,
   input  logic            LoadIR,
   input  logic            LoadMDR,
   input  logic            WriteReg,
   input  logic [1:0]      MemToReg,
   input  logic            IMemWrite,
   input  logic            DMemWrite,
   output logic [31:0]     instruction,
   output logic [XLEN-1:0] imem_addr,
   input  logic [31:0]     imem_rdata,
   output logic            imem_we,
   output logic [XLEN-1:0] dmem_addr,
   output logic [XLEN-1:0] dmem_wdata,
   input  logic [XLEN-1:0] dmem_rdata,
   output logic            dmem_we,
   output logic [XLEN-1:0] pc_out,
   output logic [XLEN-1:0] alu_out
);

   logic [XLEN-1:0] pc_q, pc_d;
   logic [31:0]     ir_q;
   logic [XLEN-1:0] a_q, b_q, aluout_q, mdr_q;

   logic [XLEN-1:0] w_imm, w_alu_a, w_alu_b, w_alu_res, w_wb_data;
   logic [XLEN-1:0] w_rs1_data, w_rs2_data;
   logic            w_zero, w_pc_load;

   // Sign-extended immediate selected by the opcode held in IR
   always_comb begin
      w_imm = '0;
      case (ir_q[6:0])
         OP_ADDI, OP_LD: w_imm = {{(XLEN-12){ir_q[31]}}, ir_q[31:20]};
         OP_S:           w_imm = {{(XLEN-12){ir_q[31]}}, ir_q[31:25], ir_q[11:7]};
         // Half-offset; the doubling is applied by operand-B select 11
         OP_SB:          w_imm = {{(XLEN-12){ir_q[31]}}, ir_q[31], ir_q[7],
                                  ir_q[30:25], ir_q[11:8]};
         OP_U:           w_imm = {{(XLEN-32){ir_q[31]}}, ir_q[31:12], 12'b0};
         OP_R:           w_imm = '0;
         default:        w_imm = '0;
      endcase
   end

   // ALU operand muxes and combinational ALU
   always_comb begin
      w_alu_a = ALUSrcA ? a_q : pc_q;
      case (ALUSrcB)
         SRCB_B:    w_alu_b = b_q;
         SRCB_FOUR: w_alu_b = XLEN'(4);
         SRCB_IMM:  w_alu_b = w_imm;
         default:   w_alu_b = w_imm << 1;
      endcase
      case (alu_funct_e'(ALUFunct))
         ALU_PASS: w_alu_res = w_alu_a;
         ALU_ADD:  w_alu_res = w_alu_a + w_alu_b;
         ALU_SUB:  w_alu_res = w_alu_a - w_alu_b;
         ALU_AND:  w_alu_res = w_alu_a & w_alu_b;
         ALU_OR:   w_alu_res = w_alu_a | w_alu_b;
         default:  w_alu_res = '0;
      endcase
   end

   assign w_zero    = (w_alu_res == '0);
   // BranchOp inverts the sense of zero, turning beq into bne
   assign w_pc_load = PCWrite | (PCWriteCond & (w_zero ^ BranchOp));
   assign pc_d      = PCSrc ? aluout_q : w_alu_res;

   // Write-back source mux for the register bank
   always_comb begin
      case (MemToReg)
         WB_ALUOUT: w_wb_data = aluout_q;
         WB_MDR:    w_wb_data = mdr_q;
         WB_IMM:    w_wb_data = w_imm;
         default:   w_wb_data = '0;
      endcase
   end

   banco_reg #(
      .XLEN (XLEN)
   ) u_banco_reg (
      .clk      (clk),
      .rst      (rst),
      .clr_i    (Reset),
      .we_i     (WriteReg),
      .rs1_i    (ir_q[19:15]),
      .rs2_i    (ir_q[24:20]),
      .rd_i     (ir_q[11:7]),
      .wdata_i  (w_wb_data),
      .rdata1_o (w_rs1_data),
      .rdata2_o (w_rs2_data)
   );

   // Architectural state registers; the control-unit clear beats every enable
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pc_q     <= '0;
         ir_q     <= '0;
         a_q      <= '0;
         b_q      <= '0;
         aluout_q <= '0;
         mdr_q    <= '0;
      end else if (Reset) begin
         pc_q     <= '0;
         ir_q     <= '0;
         a_q      <= '0;
         b_q      <= '0;
         aluout_q <= '0;
         mdr_q    <= '0;
      end else begin
         if (w_pc_load)  pc_q     <= pc_d;
         if (LoadIR)     ir_q     <= imem_rdata;
         if (LoadRegA)   a_q      <= w_rs1_data;
         if (LoadRegB)   b_q      <= w_rs2_data;
         if (LoadALUOut) aluout_q <= w_alu_res;
         if (LoadMDR)    mdr_q    <= dmem_rdata;
      end
   end

   assign instruction = ir_q;
   assign imem_addr   = pc_q;
   assign imem_we     = IMemWrite;
   assign dmem_addr   = aluout_q;
   assign dmem_wdata  = b_q;
   assign dmem_we     = DMemWrite;
   assign pc_out      = pc_q;
   assign alu_out     = aluout_q;

endmodule

`default_nettype wire

// File: tb/tb_datapath_mc.sv
// ============================================================================
// Module      : tb_datapath_mc
// Description : Directed self-checking bench for datapath_mc.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_datapath_mc;
   import riscv_pkg::*;

   logic        clk = 1'b0;
   logic        rst;
   logic        Reset, PCSrc, PCWrite, PCWriteCond, BranchOp;
   logic [2:0]  ALUFunct;
   logic        ALUSrcA;
   logic [1:0]  ALUSrcB;
   logic        LoadRegA, LoadRegB, LoadALUOut, LoadIR, LoadMDR, WriteReg;
   logic [1:0]  MemToReg;
   logic        IMemWrite, DMemWrite;
   logic [31:0] instruction, imem_rdata;
   logic [63:0] imem_addr, dmem_addr, dmem_wdata, dmem_rdata, pc_out, alu_out;
   logic        imem_we, dmem_we;

   int n_chk  = 0;
   int n_pass = 0;
   logic [63:0] rv;

   datapath_mc #(.XLEN(64)) dut (
      .clk(clk), .rst(rst), .Reset(Reset), .PCSrc(PCSrc), .PCWrite(PCWrite),
      .PCWriteCond(PCWriteCond), .BranchOp(BranchOp), .ALUFunct(ALUFunct),
      .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .LoadRegA(LoadRegA),
      .LoadRegB(LoadRegB), .LoadALUOut(LoadALUOut), .LoadIR(LoadIR),
      .LoadMDR(LoadMDR), .WriteReg(WriteReg), .MemToReg(MemToReg),
      .IMemWrite(IMemWrite), .DMemWrite(DMemWrite), .instruction(instruction),
      .imem_addr(imem_addr), .imem_rdata(imem_rdata), .imem_we(imem_we),
      .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata),
      .dmem_we(dmem_we), .pc_out(pc_out), .alu_out(alu_out)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got 0x%016h expected 0x%016h", tag, obs, exp);
   endtask

   task automatic clr();
      Reset = 0; PCSrc = 0; PCWrite = 0; PCWriteCond = 0; BranchOp = 0;
      ALUFunct = 3'b000; ALUSrcA = 0; ALUSrcB = 2'b00;
      LoadRegA = 0; LoadRegB = 0; LoadALUOut = 0; LoadIR = 0; LoadMDR = 0;
      WriteReg = 0; MemToReg = 2'b00; IMemWrite = 0; DMemWrite = 0;
   endtask

   // One clock edge with the currently driven controls, then drop them
   task automatic step();
      @(posedge clk);
      #1;
      clr();
   endtask

   task automatic load_ir(input logic [31:0] w);
      imem_rdata = w; LoadIR = 1; step();
   endtask

   task automatic load_ab();
      LoadRegA = 1; LoadRegB = 1; step();
   endtask

   task automatic fetch();
      PCWrite = 1; ALUSrcA = 0; ALUSrcB = SRCB_FOUR; ALUFunct = ALU_ADD;
      LoadIR = 1; imem_rdata = 32'h00500093;
      step();
   endtask

   // ALUOut <= x0 + imm12 (IR becomes an addi with rd = x0)
   task automatic alu_load_imm(input logic [11:0] imm);
      load_ir({imm, 5'd0, 3'b000, 5'd0, OP_ADDI});
      LoadRegA = 1; step();
      ALUSrcA = 1; ALUSrcB = SRCB_IMM; ALUFunct = ALU_ADD; LoadALUOut = 1; step();
   endtask

   // rd <= x0 + imm12 via the full addi sequence
   task automatic set_reg(input logic [4:0] rd, input logic [11:0] imm);
      load_ir({imm, 5'd0, 3'b000, rd, OP_ADDI});
      LoadRegA = 1; step();
      ALUSrcA = 1; ALUSrcB = SRCB_IMM; ALUFunct = ALU_ADD; LoadALUOut = 1; step();
      WriteReg = 1; MemToReg = WB_ALUOUT; step();
   endtask

   // Observe a bank entry by routing it through A and the pass function
   task automatic read_reg(input logic [4:0] idx, output logic [63:0] val);
      load_ir({12'h000, idx, 3'b000, 5'd0, OP_R});
      LoadRegA = 1; step();
      ALUSrcA = 1; ALUFunct = ALU_PASS; LoadALUOut = 1; step();
      val = alu_out;
   endtask

   initial begin
      clr();
      imem_rdata = '0; dmem_rdata = '0;
      rst = 1;
      #12 rst = 0;
      #2;
      // Reset state
      chk("rst_pc", pc_out, 64'h0);
      chk("rst_ir", {32'h0, instruction}, 64'h0);
      chk("rst_imem_addr", imem_addr, 64'h0);
      chk("rst_dmem_addr", dmem_addr, 64'h0);
      chk("rst_dmem_wdata", dmem_wdata, 64'h0);
      chk("rst_alu_out", alu_out, 64'h0);
      chk("rst_we", {62'h0, imem_we, dmem_we}, 64'h0);

      // Fetch: PC+4 and IR from the old PC on the same edge
      fetch();
      chk("fetch_pc", pc_out, 64'h4);
      chk("fetch_ir", {32'h0, instruction}, 64'h0000_0000_0050_0093);

      // ADDI x1, x0, 5
      LoadRegA = 1; step();
      ALUSrcA = 1; ALUSrcB = SRCB_IMM; ALUFunct = ALU_ADD; LoadALUOut = 1; step();
      chk("addi_aluout", alu_out, 64'h5);
      WriteReg = 1; MemToReg = WB_ALUOUT; step();
      read_reg(5'd1, rv);
      chk("addi_x1", rv, 64'h5);

      // ADDI x0, x0, 5 must leave x0 at zero
      set_reg(5'd0, 12'h005);
      read_reg(5'd0, rv);
      chk("x0_hardwired", rv, 64'h0);

      // BEQ taken: x1 = x2 = 7, target preloaded in ALUOut
      set_reg(5'd1, 12'h007);
      set_reg(5'd2, 12'h007);
      alu_load_imm(12'h040);
      load_ir({7'b0, 5'd2, 5'd1, 3'b000, 5'd0, OP_SB});
      load_ab();
      PCWriteCond = 1; PCSrc = 1; ALUSrcA = 1; ALUSrcB = SRCB_B;
      ALUFunct = ALU_SUB; BranchOp = 0; step();
      chk("beq_taken_pc", pc_out, 64'h40);

      // Same operands with BranchOp=1 (bne): not taken
      alu_load_imm(12'h080);
      load_ir({7'b0, 5'd2, 5'd1, 3'b000, 5'd0, OP_SB});
      load_ab();
      PCWriteCond = 1; PCSrc = 1; ALUSrcA = 1; ALUSrcB = SRCB_B;
      ALUFunct = ALU_SUB; BranchOp = 1; step();
      chk("bne_not_taken_pc", pc_out, 64'h40);

      // bne with x1=7, x3=9: taken
      set_reg(5'd3, 12'h009);
      alu_load_imm(12'h080);
      load_ir({7'b0, 5'd3, 5'd1, 3'b000, 5'd0, OP_SB});
      load_ab();
      PCWriteCond = 1; PCSrc = 1; ALUSrcA = 1; ALUSrcB = SRCB_B;
      ALUFunct = ALU_SUB; BranchOp = 1; step();
      chk("bne_taken_pc", imem_addr, 64'h80);

      // Same-cycle write and read of x5: A captures the old value
      alu_load_imm(12'h011);
      load_ir({12'h000, 5'd5, 3'b000, 5'd5, OP_ADDI});
      WriteReg = 1; MemToReg = WB_ALUOUT; LoadRegA = 1; step();
      ALUSrcA = 1; ALUFunct = ALU_PASS; LoadALUOut = 1; step();
      chk("rdw_old_value", alu_out, 64'h0);
      LoadRegA = 1; step();
      ALUSrcA = 1; ALUFunct = ALU_PASS; LoadALUOut = 1; step();
      chk("rdw_new_value", alu_out, 64'h11);

      // x2 <= 0xDEAD through MDR, then SD with S-type offset 16
      load_ir({12'h000, 5'd0, 3'b011, 5'd2, OP_LD});
      dmem_rdata = 64'hDEAD; LoadMDR = 1; step();
      WriteReg = 1; MemToReg = WB_MDR; step();
      load_ir({7'b0, 5'd2, 5'd0, 3'b011, 5'd16, OP_S});
      load_ab();
      ALUSrcA = 1; ALUSrcB = SRCB_IMM; ALUFunct = ALU_ADD; LoadALUOut = 1; step();
      DMemWrite = 1; #1;
      chk("sd_addr", dmem_addr, 64'h10);
      chk("sd_wdata", dmem_wdata, 64'hDEAD);
      chk("sd_we", {63'h0, dmem_we}, 64'h1);
      DMemWrite = 0;
      IMemWrite = 1; #1;
      chk("imem_we_pass", {63'h0, imem_we}, 64'h1);
      IMemWrite = 0;

      // LD x3 <= 0x1234
      load_ir({12'h000, 5'd0, 3'b011, 5'd3, OP_LD});
      dmem_rdata = 64'h1234; LoadMDR = 1; step();
      WriteReg = 1; MemToReg = WB_MDR; step();
      read_reg(5'd3, rv);
      chk("ld_x3", rv, 64'h1234);

      // LUI, positive and negative upper immediates, then zero write-back
      load_ir(32'h123450B7);
      WriteReg = 1; MemToReg = WB_IMM; step();
      read_reg(5'd1, rv);
      chk("lui_pos", rv, 64'h0000_0000_1234_5000);
      load_ir(32'h823450B7);
      WriteReg = 1; MemToReg = WB_IMM; step();
      read_reg(5'd1, rv);
      chk("lui_neg", rv, 64'hFFFF_FFFF_8234_5000);
      load_ir(32'h823450B7);
      WriteReg = 1; MemToReg = WB_ZERO; step();
      read_reg(5'd1, rv);
      chk("wb_zero", rv, 64'h0);

      // AND / OR / undefined function code with A=0xF0, B=0x3C
      set_reg(5'd6, 12'h0F0);
      set_reg(5'd7, 12'h03C);
      load_ir({7'b0, 5'd7, 5'd6, 3'b000, 5'd0, OP_R});
      load_ab();
      ALUSrcA = 1; ALUSrcB = SRCB_B; ALUFunct = ALU_AND; LoadALUOut = 1; step();
      chk("alu_and", alu_out, 64'h30);
      ALUSrcA = 1; ALUSrcB = SRCB_B; ALUFunct = ALU_OR; LoadALUOut = 1; step();
      chk("alu_or", alu_out, 64'hFC);
      ALUSrcA = 1; ALUSrcB = SRCB_B; ALUFunct = ALU_SUB; LoadALUOut = 1; step();
      chk("alu_sub", alu_out, 64'hB4);
      ALUSrcA = 1; ALUSrcB = SRCB_B; ALUFunct = 3'b101; LoadALUOut = 1; step();
      chk("alu_undef", alu_out, 64'h0);

      // Async rst between LoadALUOut and WriteReg
      alu_load_imm(12'h055);
      load_ir({12'h055, 5'd0, 3'b000, 5'd8, OP_ADDI});
      chk("pre_rst_aluout", alu_out, 64'h55);
      rst = 1; #2 rst = 0; #1;
      chk("async_rst_pc", pc_out, 64'h0);
      chk("async_rst_ir", {32'h0, instruction}, 64'h0);
      chk("async_rst_aluout", alu_out, 64'h0);
      WriteReg = 1; MemToReg = WB_ALUOUT; step();
      read_reg(5'd8, rv);
      chk("rst_no_write_x8", rv, 64'h0);
      read_reg(5'd2, rv);
      chk("rst_clears_x2", rv, 64'h0);

      // First fetch after release from address 0, then sync Reset beats PCWrite
      chk("post_rst_fetch_addr", imem_addr, 64'h0);
      fetch();
      chk("post_rst_fetch_pc", pc_out, 64'h4);
      PCWrite = 1; ALUSrcA = 0; ALUSrcB = SRCB_FOUR; ALUFunct = ALU_ADD;
      LoadIR = 1; imem_rdata = 32'h00500093; Reset = 1; step();
      chk("sync_reset_pc", pc_out, 64'h0);
      chk("sync_reset_ir", {32'h0, instruction}, 64'h0);

      // SB immediate doubled by operand-B select 11, PC = 0
      load_ir(32'h0000_0867);
      ALUSrcA = 0; ALUSrcB = SRCB_IMM_SH; ALUFunct = ALU_ADD; LoadALUOut = 1; step();
      chk("sb_imm_pos", alu_out, 64'h10);
      load_ir(32'h8000_0867);
      ALUSrcA = 0; ALUSrcB = SRCB_IMM_SH; ALUFunct = ALU_ADD; LoadALUOut = 1; step();
      chk("sb_imm_neg", alu_out, 64'hFFFF_FFFF_FFFF_F010);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/datapath_mc.md
# datapath_mc

Multicycle 64-bit datapath that executes the control words issued by the processor's control unit. It holds PC, IR, A, B, ALUOut and MDR, the 32×64 register bank, the immediate generator, the ALU and the branch decision logic. It drives the external instruction and data memories and returns the current instruction word to the control unit.

## Interface
- `XLEN`, default 64: datapath width.
- `clk` in 1: clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `Reset` in 1: synchronous clear from the control unit; same effect as `rst`, applied at the clock edge.
- `PCSrc` in 1: PC source. 0 selects the ALU result; 1 selects ALUOut.
- `PCWrite` in 1: unconditional PC load. `PCWriteCond` in 1: conditional PC load. `BranchOp` in 1: 0 means beq, 1 means bne.
- `ALUFunct` in 3: 000 pass A-operand, 001 add, 010 sub, 011 and, 100 or; other codes give 0.
- `ALUSrcA` in 1: 0 selects PC, 1 selects A.
- `ALUSrcB` in 2: 00 selects B, 01 selects 4, 10 selects imm, 11 selects imm<<1.
- `LoadRegA`, `LoadRegB`, `LoadALUOut`, `LoadIR`, `LoadMDR` in 1 each: register enables.
- `WriteReg` in 1: register-bank write enable. `MemToReg` in 2: write-back source. 00 ALUOut, 01 MDR, 10 imm, 11 zero.
- `IMemWrite`, `DMemWrite` in 1: passed through to the memories.
- `instruction` out 32: IR contents, consumed by the control unit.
- `imem_addr` out 64 (= PC). `imem_rdata` in 32. `imem_we` out 1.
- `dmem_addr` out 64 (= ALUOut). `dmem_wdata` out 64 (= B). `dmem_rdata` in 64. `dmem_we` out 1.
- `pc_out`, `alu_out` out 64: debug copies of PC and ALUOut.

## Operation
- Reset (`rst` async, or `Reset` sync) zeroes PC, IR, A, B, ALUOut, MDR and all 32 bank entries. All outputs read 0 after reset, including `instruction`, the addresses, `dmem_wdata`, `imem_we` and `dmem_we`.
- ALU input A = `ALUSrcA ? A : PC`. ALU input B is selected by the `ALUSrcB` mux.
- The ALU is combinational and 64-bit; add and sub wrap modulo 2^64.
- `zero` = (ALU result == 0).
- Immediate is decoded from IR[6:0], sign-extended to 64 bits:
  - I-type (0010011, 0000011): IR[31:20].
  - S-type (0100011): {IR[31:25], IR[11:7]}.
  - SB-type (1100111): {IR[31], IR[7], IR[30:25], IR[11:8]}. This is the half-offset; `ALUSrcB`=11 supplies the shift.
  - U-type (0110111): {IR[31:12], 12'b0}.
  - R-type (1100110) and unknown opcodes: 0.
- PC load condition: `PCWrite` OR (`PCWriteCond` AND (`zero` XOR `BranchOp`)).
- PC next value: `PCSrc` ? ALUOut : ALU result.
- Bank reads are asynchronous: rs1 = IR[19:15], rs2 = IR[24:20]. A and B capture them when their enables are high.
- Bank write: rd = IR[11:7], data from the `MemToReg` mux.
  - Writes to x0 are discarded; x0 always reads 0.
- IR captures `imem_rdata` on `LoadIR`. MDR captures `dmem_rdata` on `LoadMDR`.
- Write enables are honoured exactly as presented. The datapath does no decode-based filtering.
- Both memories read combinationally from the presented address. Read data must be valid in the same cycle as the matching load enable.

## Timing
- Every state register updates on the rising `clk` edge where its enable is sampled high. Outputs are registered values, so they change only after that edge.
- IR, PC, A, B, ALUOut and MDR may all load on the same edge. Each uses pre-edge values, e.g. fetch writes PC+4 and IR from the old PC simultaneously.
- Same-cycle bank read and write to the same register: the read returns the old value. The new value is visible the next cycle.
- `imem_we` and `dmem_we` are combinational pass-throughs. A write occurs at the memory on the edge where they are high.
- Branch decision uses `zero` from the same cycle's ALU, which has zero cycles of latency.
- `rst` asserted mid-instruction clears everything immediately, regardless of `clk`. The first fetch after release reads from address 0.
- `Reset` takes priority over all enables on the same edge.

## Structure
- Shared package `riscv_pkg`:
  - opcode constants (R 1100110, S 0100011, ADDI 0010011, LD 0000011, U 0110111, SB 1100111);
  - `ALUFunct` enum;
  - `ALUSrcB` and `MemToReg` encodings.
- The control unit imports the same package.
- Sub-module `banco_reg`: 32×64 bank with two async read ports, one sync write port, x0 hardwired, async reset.
- Immediate generator and ALU stay inline as `always_comb` blocks.

## Test plan
- Reset, then one fetch cycle (PCWrite=1, ALUSrcA=0, ALUSrcB=01, ALUFunct=001, LoadIR=1, imem_rdata=0x00500093) -> PC=4, `instruction`=0x00500093.
- ADDI sequence: LoadRegA, then ALUSrcA=1/ALUSrcB=10/add/LoadALUOut, then WriteReg with MemToReg=00 -> x1=5. With IR rd=0 instead -> x0 still reads 0.
- BEQ with x1=x2=7, ALUOut=0x40 preloaded: PCWriteCond=1, PCSrc=1, sub, BranchOp=0 -> PC=0x40. Repeat with BranchOp=1 -> PC unchanged.
- SD: B=0xDEAD, ALUOut=16, DMemWrite=1 -> dmem_addr=16, dmem_wdata=0xDEAD, dmem_we=1. LD: dmem_rdata=0x1234, LoadMDR, then WriteReg with MemToReg=01 -> rd=0x1234.
- LUI with IR=0x123450B7, WriteReg=1, MemToReg=10 -> x1=0x0000000012345000. With IR[31]=1 -> upper 32 bits all ones.
- Pulse `rst` between LoadALUOut and WriteReg -> no bank write, all registers 0. Assert `Reset` together with PCWrite -> PC=0.
